// File: rtl/striping_pkg.sv
// Shared types and constants for the two-lane striping scheduler.
package striping_pkg;

  localparam int DATA_W    = 32;
  localparam int NUM_LANES = 2;

  // Encoding matches lane_en bit-for-bit so the mode loads directly from it.
  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_SINGLE0 = 2'b01,
    MODE_SINGLE1 = 2'b10,
    MODE_DUAL    = 2'b11
  } mode_e;

endpackage

// File: rtl/striping_sched_if.sv
// Word stream in and the two lane outputs of the striping scheduler.
interface striping_sched_if;
  import striping_pkg::*;

  logic [DATA_W-1:0] data_in;
  logic              valid_in;
  logic              ready_in;
  logic [DATA_W-1:0] lane_0;
  logic [DATA_W-1:0] lane_1;
  logic              valid_0;
  logic              valid_1;

  modport master (
    output data_in, valid_in,
    input  ready_in, lane_0, lane_1, valid_0, valid_1
  );

  modport slave (
    input  data_in, valid_in,
    output ready_in, lane_0, lane_1, valid_0, valid_1
  );

endinterface

// File: rtl/stripe_credit_ctr.sv
// Per-lane credit counter: decrements on send, increments on return,
// drops returns at a full counter and latches a sticky overflow flag.
module stripe_credit_ctr #(
  parameter int MAX_CREDITS = 4,
  parameter int CW          = $clog2(MAX_CREDITS + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic dec,
  input  logic inc,
  output logic has_credit,
  output logic ovf
);

  localparam logic [CW-1:0] FULL = CW'(MAX_CREDITS);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  // Next count; a simultaneous send and return cancel out.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (inc && !dec) begin
      if (cnt_q == FULL) ovf_d = 1'b1;
      else               cnt_d = cnt_q + 1'b1;
    end else if (dec && !inc) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter and flag registers; reset refills the lane.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= FULL;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign has_credit = (cnt_q != '0);
  assign ovf        = ovf_q;

endmodule

// File: rtl/striping_sched.sv
// Two-lane round-robin striping scheduler with per-lane credit backpressure.
// Optional statistics counters are built when STRIPE_STATS_EN is defined.
module striping_sched import striping_pkg::*; #(
  parameter int MAX_CREDITS = 4,
  parameter int CW          = $clog2(MAX_CREDITS + 1)
) (
  input  logic                   clk_2f,
  input  logic                   reset,
  striping_sched_if.slave        bus,
  input  logic [1:0]             lane_en,
  input  logic                   credit_ret_0,
  input  logic                   credit_ret_1,
  output logic                   err_credit_ovf
`ifdef STRIPE_STATS_EN
  ,
  output logic [31:0]            words_0,
  output logic [31:0]            words_1,
  output logic [31:0]            stall_cnt
`endif
);

  mode_e                mode_q, mode_d;
  logic                 ptr_q, ptr_d;
  logic                 tgt;
  logic                 ready;
  logic                 accept;
  logic                 send_0, send_1;
  logic [NUM_LANES-1:0] has_cred;
  logic [NUM_LANES-1:0] ovf;
  logic [DATA_W-1:0]    lane_0_q, lane_0_d, lane_1_q, lane_1_d;
  logic                 valid_0_q, valid_0_d, valid_1_q, valid_1_d;

  stripe_credit_ctr #(.MAX_CREDITS(MAX_CREDITS), .CW(CW)) u_cred_0 (
    .clk(clk_2f), .rst(reset), .dec(send_0), .inc(credit_ret_0),
    .has_credit(has_cred[0]), .ovf(ovf[0])
  );

  stripe_credit_ctr #(.MAX_CREDITS(MAX_CREDITS), .CW(CW)) u_cred_1 (
    .clk(clk_2f), .rst(reset), .dec(send_1), .inc(credit_ret_1),
    .has_credit(has_cred[1]), .ovf(ovf[1])
  );

  // Target lane and ready depend only on registered state, never on valid_in.
  always_comb begin
    tgt = 1'b0;
    unique case (mode_q)
      MODE_SINGLE1: tgt = 1'b1;
      MODE_DUAL:    tgt = ptr_q;
      default:      tgt = 1'b0;
    endcase
    ready  = (mode_q != MODE_OFF) && has_cred[tgt] && !reset;
    accept = bus.valid_in && ready;
    send_0 = accept && !tgt;
    send_1 = accept && tgt;
  end

  // Pointer advances per accept in DUAL; mode reloads only at pair boundaries.
  always_comb begin
    ptr_d     = (mode_q == MODE_DUAL) ? (ptr_q ^ accept) : 1'b0;
    mode_d    = ptr_d ? mode_q : mode_e'(lane_en);
    lane_0_d  = send_0 ? bus.data_in : lane_0_q;
    lane_1_d  = send_1 ? bus.data_in : lane_1_q;
    valid_0_d = send_0;
    valid_1_d = send_1;
  end

  // Mode/pointer FSM and lane output registers.
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      mode_q    <= MODE_OFF;
      ptr_q     <= 1'b0;
      lane_0_q  <= '0;
      lane_1_q  <= '0;
      valid_0_q <= 1'b0;
      valid_1_q <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      ptr_q     <= ptr_d;
      lane_0_q  <= lane_0_d;
      lane_1_q  <= lane_1_d;
      valid_0_q <= valid_0_d;
      valid_1_q <= valid_1_d;
    end
  end

  assign bus.ready_in   = ready;
  assign bus.lane_0     = lane_0_q;
  assign bus.lane_1     = lane_1_q;
  assign bus.valid_0    = valid_0_q;
  assign bus.valid_1    = valid_1_q;
  assign err_credit_ovf = |ovf;

`ifdef STRIPE_STATS_EN
  logic [31:0] words_0_q, words_0_d, words_1_q, words_1_d, stall_q, stall_d;

  // Free-running wrap-around statistics.
  always_comb begin
    words_0_d = words_0_q + {31'd0, send_0};
    words_1_d = words_1_q + {31'd0, send_1};
    stall_d   = stall_q + {31'd0, (bus.valid_in && !ready)};
  end

  // Statistics registers.
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      words_0_q <= '0;
      words_1_q <= '0;
      stall_q   <= '0;
    end else begin
      words_0_q <= words_0_d;
      words_1_q <= words_1_d;
      stall_q   <= stall_d;
    end
  end

  assign words_0   = words_0_q;
  assign words_1   = words_1_q;
  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_striping_sched.sv
// Scoreboard bench for striping_sched: a reference model predicts ready,
// lane selection, credits and the overflow flag every cycle.
module tb_striping_sched;
  import striping_pkg::*;

  localparam int MAXC = 4;

  logic       clk_2f = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] lane_en = 2'b00;
  logic       credit_ret_0 = 1'b0;
  logic       credit_ret_1 = 1'b0;
  logic       err_credit_ovf;
`ifdef STRIPE_STATS_EN
  logic [31:0] words_0, words_1, stall_cnt;
`endif

  striping_sched_if bus ();

  striping_sched #(.MAX_CREDITS(MAXC)) dut (
    .clk_2f(clk_2f),
    .reset(reset),
    .bus(bus),
    .lane_en(lane_en),
    .credit_ret_0(credit_ret_0),
    .credit_ret_1(credit_ret_1),
    .err_credit_ovf(err_credit_ovf)
`ifdef STRIPE_STATS_EN
    ,
    .words_0(words_0),
    .words_1(words_1),
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk_2f = ~clk_2f;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask

  typedef struct packed {
    logic        lane;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state
  logic [1:0] m_mode = 2'b00;
  logic       m_ptr  = 1'b0;
  int         m_cred[2] = '{MAXC, MAXC};
  logic       m_err  = 1'b0;
  logic [31:0] m_w0 = 0, m_w1 = 0, m_stall = 0;
  logic       seen_aaaa = 1'b0;

  always @(negedge clk_2f) begin : monitor
    exp_t e;
    logic m_tgt, m_rdy, acc;
    logic [1:0] snd, ret;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("lane_sel", 32'({bus.valid_1, bus.valid_0}), e.lane ? 32'd2 : 32'd1);
      if (e.lane) check("lane1_data", bus.lane_1, e.data);
      else        check("lane0_data", bus.lane_0, e.data);
    end else begin
      check("no_valid", 32'({bus.valid_1, bus.valid_0}), 32'd0);
    end
    if ((bus.valid_0 && bus.lane_0 == 32'hAAAAAAAA) ||
        (bus.valid_1 && bus.lane_1 == 32'hAAAAAAAA)) seen_aaaa = 1'b1;

    m_tgt = (m_mode == 2'b11) ? m_ptr : (m_mode == 2'b10);
    m_rdy = !reset && (m_mode != 2'b00) && (m_cred[m_tgt] > 0);
    check("ready_in", 32'(bus.ready_in), 32'(m_rdy));
    check("err_ovf", 32'(err_credit_ovf), 32'(m_err));
`ifdef STRIPE_STATS_EN
    check("words_0", words_0, m_w0);
    check("words_1", words_1, m_w1);
    check("stall_cnt", stall_cnt, m_stall);
`endif

    if (reset) begin
      m_mode = 2'b00; m_ptr = 1'b0; m_err = 1'b0;
      m_cred[0] = MAXC; m_cred[1] = MAXC;
      m_w0 = 0; m_w1 = 0; m_stall = 0;
    end else begin
      acc = bus.valid_in && m_rdy;
      if (acc) begin
        e.lane = m_tgt;
        e.data = bus.data_in;
        sb_q.push_back(e);
      end
      snd[0] = acc && !m_tgt;
      snd[1] = acc && m_tgt;
      ret[0] = credit_ret_0;
      ret[1] = credit_ret_1;
      for (int i = 0; i < 2; i++) begin
        if (ret[i] && !snd[i] && m_cred[i] == MAXC) m_err = 1'b1;
        else m_cred[i] = m_cred[i] + int'(ret[i]) - int'(snd[i]);
      end
      m_w0 = m_w0 + 32'(snd[0]);
      m_w1 = m_w1 + 32'(snd[1]);
      if (bus.valid_in && !m_rdy) m_stall = m_stall + 1;
      if (m_mode == 2'b11) m_ptr = m_ptr ^ acc;
      else                 m_ptr = 1'b0;
      if (!m_ptr) m_mode = lane_en;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_2f);
      #1;
    end
  endtask

  task automatic do_reset(input logic [1:0] en);
    reset = 1'b1;
    lane_en = en;
    bus.valid_in = 1'b0;
    tick(2);
    reset = 1'b0;
  endtask

  // Hold a word on the input for up to budget cycles; report if it was taken.
  task automatic offer(input logic [31:0] d, input int budget, output bit acc);
    bus.data_in = d;
    bus.valid_in = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < budget && !acc; i++) begin
      @(negedge clk_2f);
      acc = bus.ready_in;
      @(posedge clk_2f);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    logic [31:0] words[4];
    bus.data_in = '0;
    bus.valid_in = 1'b0;

    // Reset state
    do_reset(2'b11);
    check("rst_lane0", bus.lane_0, 32'd0);
    check("rst_lane1", bus.lane_1, 32'd0);
    check("rst_ready", 32'(bus.ready_in), 32'd0);

    // Dual-mode striping, back-to-back
    words = '{32'hFFFFFFFF, 32'hEEEEEEEE, 32'hDDDDDDDD, 32'hCCCCCCCC};
    offer(words[0], 3, acc);
    check("t1_acc0", 32'(acc), 32'd1);
    for (int i = 1; i < 4; i++) begin
      offer(words[i], 1, acc);
      check("t1_acc", 32'(acc), 32'd1);
    end
    bus.valid_in = 1'b0;
    check("t1_lane0_last", bus.lane_0, 32'hDDDDDDDD);
    check("t1_lane1_last", bus.lane_1, 32'hCCCCCCCC);
    tick(2);

    // Credit stall after 8 accepts, release with single returns
    do_reset(2'b11);
    for (int i = 1; i <= 8; i++) begin
      offer(32'(i), 3, acc);
      check("t2_acc", 32'(acc), 32'd1);
    end
    offer(32'd9, 4, acc);
    check("t2_stall9", 32'(acc), 32'd0);
    credit_ret_0 = 1'b1;
    tick(1);
    credit_ret_0 = 1'b0;
    offer(32'd9, 1, acc);
    check("t2_acc9", 32'(acc), 32'd1);
    offer(32'd10, 3, acc);
    check("t2_stall10", 32'(acc), 32'd0);
    credit_ret_1 = 1'b1;
    tick(1);
    credit_ret_1 = 1'b0;
    offer(32'd10, 1, acc);
    check("t2_acc10", 32'(acc), 32'd1);
    bus.valid_in = 1'b0;
    tick(2);

    // Mode change mid-pair: B completes the pair, then lane 0 only
    do_reset(2'b11);
    offer(32'h0000000A, 3, acc);
    check("t3_accA", 32'(acc), 32'd1);
    lane_en = 2'b01;
    offer(32'h0000000B, 1, acc);
    check("t3_accB", 32'(acc), 32'd1);
    offer(32'h0000000C, 1, acc);
    check("t3_accC", 32'(acc), 32'd1);
    offer(32'h0000000D, 1, acc);
    check("t3_accD", 32'(acc), 32'd1);
    bus.valid_in = 1'b0;
    check("t3_lane0", bus.lane_0, 32'h0000000D);
    check("t3_lane1", bus.lane_1, 32'h0000000B);
    tick(2);

    // Lanes off
    do_reset(2'b00);
    offer(32'h00000200, 6, acc);
    check("t4_off_acc", 32'(acc), 32'd0);
    bus.valid_in = 1'b0;
    tick(1);

    // Credit overflow on lane 1
    do_reset(2'b00);
    tick(1);
    credit_ret_1 = 1'b1;
    tick(1);
    credit_ret_1 = 1'b0;
    check("t5_ovf_set", 32'(err_credit_ovf), 32'd1);
    tick(3);
    check("t5_ovf_sticky", 32'(err_credit_ovf), 32'd1);
    lane_en = 2'b11;
    tick(1);
    for (int i = 0; i < 8; i++) begin
      offer(32'h00000100 + 32'(i), 3, acc);
      check("t5_acc", 32'(acc), 32'd1);
    end
    offer(32'h00000109, 3, acc);
    check("t5_stall", 32'(acc), 32'd0);
    bus.valid_in = 1'b0;
    tick(1);

    // Reset mid-stream
    do_reset(2'b11);
    offer(32'h00000011, 3, acc);
    check("t6_acc_pre", 32'(acc), 32'd1);
    bus.data_in = 32'hAAAAAAAA;
    bus.valid_in = 1'b1;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    offer(32'h00000005, 4, acc);
    check("t6_acc5", 32'(acc), 32'd1);
    bus.valid_in = 1'b0;
    check("t6_lane0", bus.lane_0, 32'h00000005);
    tick(2);
    check("t6_no_aaaa", 32'(seen_aaaa), 32'd0);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
